// File: rtl/disp_pkg.sv
// Shared types and constants for the disparity frame sink: FSM encoding,
// default frame geometry and the byte/half-word lane layout of a packed word.
package disp_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDrain  = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam int unsigned DefWidth  = 320;
    localparam int unsigned DefHeight = 240;

    localparam int unsigned EvenByteLsb = 0;
    localparam int unsigned OddByteLsb  = 8;
    localparam int unsigned LoHalfLsb   = 0;
    localparam int unsigned HiHalfLsb   = 16;

    function automatic logic [15:0] pack_pair(logic [7:0] even, logic [7:0] odd);
        logic [15:0] p;
        p = '0;
        p[EvenByteLsb +: 8] = even;
        p[OddByteLsb +: 8]  = odd;
        return p;
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with synchronous flush; head is presented combinationally
// and forced to zero while empty.
module sync_word_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = empty ? '0 : mem_q[rd_q];

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/disparity_frame_sink.sv
// Packs incoming pixel pairs into 32-bit words, addresses them row by row
// (optionally bottom-up) and streams them to memory through a word FIFO.
module disparity_frame_sink
    import disp_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned HEIGHT     = DefHeight,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BMP_FLIP   = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic [7:0]        DATA_0,
    input  logic [7:0]        DATA_1,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              frame_done,
    output logic              err
);

    localparam int unsigned WordsPerRow = WIDTH / 4;
    localparam int unsigned ColW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned RowW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned CntW        = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q;
    logic [ColW-1:0]   col_q;
    logic [RowW-1:0]   row_q;
    logic [15:0]       lo_half_q;
    logic              push_q;
    logic [31:0]       push_word_q;
    logic [ADDR_W-1:0] push_addr_q;

    logic [ADDR_W-1:0] row_a, addr_next;
    logic [31:0]       word_next;
    logic [31+ADDR_W:0] head;
    logic              fifo_full, fifo_empty, pop, overflow, col_last, row_last, last_pop;
    logic [CntW-1:0]   fifo_count;

    sync_word_fifo #(
        .DW    (32 + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .flush (VSYNC),
        .push  (push_q),
        .wdata ({push_addr_q, push_word_q}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_valid = !fifo_empty;
    assign wr_addr  = head[31+ADDR_W:32];
    assign wr_data  = head[31:0];
    assign pop      = wr_valid && wr_ready;
    assign overflow = push_q && fifo_full && !pop;
    assign col_last = (col_q == ColW'(WIDTH - 2));
    assign row_last = (row_q == RowW'(HEIGHT - 1));
    // Final acceptance: the only word left is leaving and nothing is about to enter.
    assign last_pop = pop && (fifo_count == CntW'(1)) && !push_q;

    always_comb begin
        row_a = (BMP_FLIP != 0) ? ADDR_W'(HEIGHT - 1) - ADDR_W'(row_q) : ADDR_W'(row_q);
        addr_next = row_a * ADDR_W'(WordsPerRow) + ADDR_W'(col_q >> 2);
        word_next = '0;
        word_next[LoHalfLsb +: 16] = lo_half_q;
        word_next[HiHalfLsb +: 16] = pack_pair(DATA_0, DATA_1);
    end

    // col_q[1] doubles as the pack phase: clear on the first beat of a word.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            lo_half_q   <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            push_addr_q <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            frame_done <= 1'b0;
            if (VSYNC) begin
                state_q <= StActive;
                row_q   <= '0;
                err     <= 1'b0;
                if (HSYNC) begin
                    col_q     <= ColW'(2);
                    lo_half_q <= pack_pair(DATA_0, DATA_1);
                end else begin
                    col_q <= '0;
                end
            end else begin
                if (overflow) err <= 1'b1;
                unique case (state_q)
                    StActive: begin
                        if (HSYNC) begin
                            if (col_q[1]) begin
                                push_q      <= 1'b1;
                                push_word_q <= word_next;
                                push_addr_q <= addr_next;
                            end else begin
                                lo_half_q <= pack_pair(DATA_0, DATA_1);
                            end
                            if (col_last) begin
                                col_q <= '0;
                                if (row_last) state_q <= StDrain;
                                else          row_q   <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + ColW'(2);
                            end
                        end
                    end
                    StDrain: begin
                        if (last_pop) begin
                            frame_done <= 1'b1;
                            state_q    <= StDone;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
